motor_ramp_scheduler: RTL and testbench
=======================================

Name: motor_ramp_scheduler

Overview:
Sequences all writes into the 6-motor slave controller (reg 0: 12-bit enable/direction word; reg 1: 5-bit shared duty cycle). The host writes target values; this block ramps duty toward the target and forces ramp-to-zero plus dead time before any enable/direction change. A watchdog stops all motors if the host goes silent. It sits between the host Avalon slave port and the motor slave's write port.

Parameters:
RAMP_DIV, 50000, clk cycles per ramp tick (≥1)
DUTY_STEP, 1, duty change per tick (1..31)
DEAD_CYCLES, 50000, cycles at duty 0 before the direction write (≥1)
WDT_CYCLES, 50000000, host-silence timeout in cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
write  in  1  host write strobe
address  in  2  host register select
writedata  in  32  host write data
readdata  out  32  combinational read of the addressed register
out_write  out  1  single-cycle write pulse to the motor slave
out_addr  out  1  0 = dir word, 1 = duty
out_writedata  out  32  zero-extended dir[11:0] or duty[4:0]
wdt_tripped  out  1  sticky watchdog-expired flag

Behaviour:
- Host registers:
  - addr0: tgt_dir <= wd[11:0].
  - addr1: tgt_duty <= wd[4:0].
  - addr2: RO status {state[2:0] @[20:18], wdt_tripped @17, cur_duty @[16:12], cur_dir @[11:0]}; writes ignored.
  - addr3: wd[0]=1 clears wdt_tripped; wd[1]=1 e-stop (tgt_dir<=0, tgt_duty<=0).
  - Reads of addr0/1 return targets, zero-extended.
- cur_dir/cur_duty mirror the last values written out.
- Reset: all regs 0, out_write=0, out_addr=0, out_writedata=0, wdt_tripped=0, state INIT.
- Tick prescaler: free-running 0..RAMP_DIV-1; tick is high for one cycle at wrap; cleared by reset.
- At most one out_write per cycle. Each out_write is accompanied by its addr/data in the same cycle. out_addr/out_writedata hold their last values when out_write=0.
- States:
  - INIT1: write addr1 duty 0.
  - INIT2 (next cycle): write addr0 dir 0, then go to TRACK. No tick wait; INIT1 and INIT2 occupy the first two cycles after reset deasserts.
  - TRACK:
    - If tgt_dir≠cur_dir: go to DEADTIME if cur_duty==0, else RAMP_DOWN.
    - Else on tick with cur_duty≠tgt_duty: step cur_duty toward tgt_duty by DUTY_STEP, clamped so it never overshoots, and write addr1.
  - RAMP_DOWN:
    - On tick: cur_duty <= max(cur_duty-DUTY_STEP, 0) and write addr1.
    - At 0, go to DEADTIME.
    - If tgt_dir returns to cur_dir, go to TRACK with no write that cycle.
  - DEADTIME:
    - Counter loads at entry. After exactly DEAD_CYCLES cycles in DEADTIME, go to WR_DIR.
    - If tgt_dir==cur_dir at any point, go to TRACK with no dir write.
  - WR_DIR: write addr0 with tgt_dir, cur_dir <= tgt_dir, go to TRACK. Duty then ramps up from 0 on subsequent ticks.
- tgt_dir is sampled in WR_DIR. A host change during DEADTIME is used, and the dead time is not restarted.
- Watchdog:
  - Counter clears on any host write to addr0/1/3 and on reset.
  - When it reaches WDT_CYCLES: tgt_dir<=0, tgt_duty<=0, wdt_tripped<=1, counter holds at expiry until the next host write.
  - A host write in the same cycle as expiry wins: targets take the host data, the counter clears, and there is no trip.
  - Tripping does not lock out host writes; recovery is via normal target writes.
- Same-cycle host write and tick: the step uses the pre-write targets; the new target is effective from the next cycle.
- Reset mid-sequence (any state): everything is aborted and INIT is re-entered. INIT guarantees the motor slave, which has no reset, is forced off.
- Latency: a host duty change reaches the first addr1 write on the next tick (1..RAMP_DIV cycles).

Decomposition:
- Package mc_pkg:
  - DIR_W=12, DUTY_W=5, N_MOTORS=6.
  - Register address constants ADDR_DIR/ADDR_DUTY/ADDR_STATUS/ADDR_CTRL.
  - State encoding INIT1=0, INIT2=1, TRACK=2, RAMP_DOWN=3, DEADTIME=4, WR_DIR=5.
- One sub-module, mc_prescaler (parameter DIV; ports clk, reset, tick). The watchdog and deadtime counters stay inline.

Test Plan (RAMP_DIV=4, DUTY_STEP=1, DEAD_CYCLES=8, WDT_CYCLES=200):
1. Release reset -> cycle 1: out_write addr1 data 0; cycle 2: addr0 data 0; then no writes while targets are 0.
2. Write dir=0x001 then duty=5 -> after DEADTIME (8 cycles), addr0 0x001; then addr1 writes 1,2,3,4,5 exactly 4 cycles apart; then none.
3. At duty 5, dir 0x001, write dir=0x003 -> addr1 writes 4..0 every 4 cycles; 8 cycles later addr0 0x003; duty ramps back 1..5; no addr0 write while duty≠0.
4. During DEADTIME, write dir back to the old value -> no addr0 write; state returns to TRACK; duty ramps to target.
5. Run at duty 5, no host writes for 200 cycles -> wdt_tripped=1, duty ramps 4..0, then addr0 0x000. Write addr3 wd=1 -> wdt_tripped=0.
6. Assert reset for 1 cycle during RAMP_DOWN at duty 3 -> all outputs 0, then the INIT1/INIT2 writes (duty 0, dir 0) reappear in the two cycles after reset.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared widths, register map, state encoding and duty step helper
package mc_pkg;

    localparam int N_MOTORS = 6;
    localparam int DIR_W    = 2 * N_MOTORS;
    localparam int DUTY_W   = 5;

    localparam logic [1:0] ADDR_DIR    = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT1     = 3'd0,
        ST_INIT2     = 3'd1,
        ST_TRACK     = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DEADTIME  = 3'd4,
        ST_WR_DIR    = 3'd5
    } state_t;

    // Move cur toward tgt by at most step, landing exactly on tgt instead of overshooting.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W-1:0] res;
        if (tgt > cur) begin
            res = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else begin
            res = ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/mc_prescaler.sv
// rtl/mc_prescaler.sv - free-running divider producing a one-cycle ramp tick
module mc_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..DIV-1 and wrap; tick marks the wrap cycle.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_ramp_scheduler.sv
// rtl/motor_ramp_scheduler.sv - host-facing ramp/deadtime/watchdog sequencer for the 6-motor slave
module motor_ramp_scheduler #(
    parameter int RAMP_DIV    = 50000,
    parameter int DUTY_STEP   = 1,
    parameter int DEAD_CYCLES = 50000,
    parameter int WDT_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_write,
    output logic        out_addr,
    output logic [31:0] out_writedata,
    output logic        wdt_tripped
);
    import mc_pkg::*;

    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(DUTY_STEP);
    localparam logic [31:0]       DEAD_LOAD = 32'(DEAD_CYCLES - 1);
    localparam logic [31:0]       WDT_LIM   = 32'(WDT_CYCLES);
    localparam bit                WDT_ON    = (WDT_CYCLES != 0);

    logic              tick;
    state_t            state, state_d;
    logic [DIR_W-1:0]  tgt_dir, cur_dir, cur_dir_d;
    logic [DUTY_W-1:0] tgt_duty, cur_duty, cur_duty_d;
    logic [DUTY_W-1:0] duty_track, duty_down;
    logic [31:0]       dead_cnt, dead_cnt_d;
    logic              out_write_d, out_addr_d;
    logic [31:0]       out_writedata_d;
    logic [31:0]       wdt_cnt;
    logic              host_wr, wdt_expire;
    logic              unused_wd;

    assign unused_wd = ^writedata[31:DIR_W];

    mc_prescaler #(.DIV(RAMP_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign host_wr    = write && (address != ADDR_STATUS);
    // A host write in the expiry cycle takes priority, so it suppresses the trip.
    assign wdt_expire = WDT_ON && (wdt_cnt == WDT_LIM) && !host_wr;

    assign duty_track = step_toward(cur_duty, tgt_duty, STEP);
    assign duty_down  = step_toward(cur_duty, '0, STEP);

    // Host target registers, control actions and the host-silence watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_dir     <= '0;
            tgt_duty    <= '0;
            wdt_tripped <= 1'b0;
            wdt_cnt     <= '0;
        end else if (host_wr) begin
            wdt_cnt <= '0;
            case (address)
                ADDR_DIR:  tgt_dir  <= writedata[DIR_W-1:0];
                ADDR_DUTY: tgt_duty <= writedata[DUTY_W-1:0];
                default: begin
                    if (writedata[0]) wdt_tripped <= 1'b0;
                    if (writedata[1]) begin
                        tgt_dir  <= '0;
                        tgt_duty <= '0;
                    end
                end
            endcase
        end else if (wdt_expire) begin
            tgt_dir     <= '0;
            tgt_duty    <= '0;
            wdt_tripped <= 1'b1;
        end else if (WDT_ON) begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end

    // Sequencer state, mirrored motor values and registered slave write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT1;
            cur_dir       <= '0;
            cur_duty      <= '0;
            dead_cnt      <= '0;
            out_write     <= 1'b0;
            out_addr      <= 1'b0;
            out_writedata <= '0;
        end else begin
            state         <= state_d;
            cur_dir       <= cur_dir_d;
            cur_duty      <= cur_duty_d;
            dead_cnt      <= dead_cnt_d;
            out_write     <= out_write_d;
            out_addr      <= out_addr_d;
            out_writedata <= out_writedata_d;
        end
    end

    // Next-state and slave-write decisions; all steps use the pre-write targets.
    always_comb begin
        state_d         = state;
        cur_dir_d       = cur_dir;
        cur_duty_d      = cur_duty;
        dead_cnt_d      = dead_cnt;
        out_write_d     = 1'b0;
        out_addr_d      = out_addr;
        out_writedata_d = out_writedata;
        case (state)
            ST_INIT1: begin
                out_write_d     = 1'b1;
                out_addr_d      = 1'b1;
                out_writedata_d = '0;
                cur_duty_d      = '0;
                state_d         = ST_INIT2;
            end
            ST_INIT2: begin
                out_write_d     = 1'b1;
                out_addr_d      = 1'b0;
                out_writedata_d = '0;
                cur_dir_d       = '0;
                state_d         = ST_TRACK;
            end
            ST_TRACK: begin
                if (tgt_dir != cur_dir) begin
                    if (cur_duty == '0) begin
                        state_d    = ST_DEADTIME;
                        dead_cnt_d = DEAD_LOAD;
                    end else begin
                        state_d = ST_RAMP_DOWN;
                    end
                end else if (tick && (cur_duty != tgt_duty)) begin
                    cur_duty_d      = duty_track;
                    out_write_d     = 1'b1;
                    out_addr_d      = 1'b1;
                    out_writedata_d = {{(32-DUTY_W){1'b0}}, duty_track};
                end
            end
            ST_RAMP_DOWN: begin
                if (tgt_dir == cur_dir) begin
                    state_d = ST_TRACK;
                end else if (cur_duty == '0) begin
                    state_d    = ST_DEADTIME;
                    dead_cnt_d = DEAD_LOAD;
                end else if (tick) begin
                    cur_duty_d      = duty_down;
                    out_write_d     = 1'b1;
                    out_addr_d      = 1'b1;
                    out_writedata_d = {{(32-DUTY_W){1'b0}}, duty_down};
                end
            end
            ST_DEADTIME: begin
                if (tgt_dir == cur_dir) begin
                    state_d = ST_TRACK;
                end else if (dead_cnt == '0) begin
                    state_d = ST_WR_DIR;
                end else begin
                    dead_cnt_d = dead_cnt - 32'd1;
                end
            end
            ST_WR_DIR: begin
                out_write_d     = 1'b1;
                out_addr_d      = 1'b0;
                out_writedata_d = {{(32-DIR_W){1'b0}}, tgt_dir};
                cur_dir_d       = tgt_dir;
                state_d         = ST_TRACK;
            end
            default: begin
                state_d = ST_INIT1;
            end
        endcase
    end

    // Host read mux: targets, live status word, control reads as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DIR:    readdata = {{(32-DIR_W){1'b0}}, tgt_dir};
            ADDR_DUTY:   readdata = {{(32-DUTY_W){1'b0}}, tgt_duty};
            ADDR_STATUS: readdata = {11'b0, state, wdt_tripped, cur_duty, cur_dir};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// tb/tb_motor_ramp_scheduler.sv - scoreboard bench for motor_ramp_scheduler
module tb_motor_ramp_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_write;
    logic        out_addr;
    logic [31:0] out_writedata;
    logic        wdt_tripped;

    typedef struct {
        logic        addr;
        logic [31:0] data;
        int          gap;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_wr = -1000;

    localparam logic [31:0] ST_MASK   = 32'h7 << 18;
    localparam logic [31:0] DUTY_MASK = 32'h1f << 12;

    motor_ramp_scheduler #(
        .RAMP_DIV    (4),
        .DUTY_STEP   (1),
        .DEAD_CYCLES (8),
        .WDT_CYCLES  (200)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .out_write     (out_write),
        .out_addr      (out_addr),
        .out_writedata (out_writedata),
        .wdt_tripped   (wdt_tripped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic expect_wr(input logic a, input logic [31:0] d, input int gap, input string nm);
        exp_t x;
        x.addr = a;
        x.data = d;
        x.gap  = gap;
        x.name = nm;
        sb.push_back(x);
    endtask

    // Monitor: every slave write pops the next expectation; gap is cycles since the previous write.
    always @(negedge clk) begin
        cyc++;
        if (out_write === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", out_addr, out_writedata);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_addr"}, {31'b0, out_addr}, {31'b0, e.addr});
                chk({e.name, "_data"}, out_writedata, e.data);
                if (e.gap != 0) chk({e.name, "_gap"}, 32'(cyc - last_wr), 32'(e.gap));
            end
            last_wr = cyc;
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        write     = 1'b1;
        address   = a;
        writedata = d;
        @(posedge clk); #1;
        write     = 1'b0;
        address   = 2'd2;
        writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] req, input string nm);
        address = a;
        #1;
        chk(nm, readdata, req);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, input int budget,
                               input string nm);
        address = 2'd2;
        #1;
        for (int i = 0; i < budget && ((readdata & mask) != val); i++) begin
            @(posedge clk); #1;
        end
        chk(nm, readdata & mask, val);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        write     = 1'b0;
        address   = 2'd2;
        writedata = '0;
        repeat (3) @(posedge clk);
        #1;

        // 1: reset values, then INIT writes duty 0 / dir 0 on consecutive cycles
        chk("rst_out_write", {31'b0, out_write}, 32'd0);
        chk("rst_out_addr", {31'b0, out_addr}, 32'd0);
        chk("rst_out_data", out_writedata, 32'd0);
        chk("rst_wdt", {31'b0, wdt_tripped}, 32'd0);
        chk("rst_status", readdata, 32'd0);
        expect_wr(1'b1, 32'd0, 0, "t1_init1");
        expect_wr(1'b0, 32'd0, 1, "t1_init2");
        reset = 1'b0;
        wait_drain(10, "t1");
        idle(12);
        rd(2'd2, 32'(2) << 18, "t1_status");

        // 2: dir 1 after deadtime, then duty ramps 1..5 one per tick
        expect_wr(1'b0, 32'h001, 0, "t2_dir");
        for (int k = 1; k <= 5; k++) expect_wr(1'b1, 32'(k), (k == 1) ? 0 : 4, "t2_up");
        host_write(2'd0, 32'h001);
        host_write(2'd1, 32'd5);
        wait_drain(80, "t2");
        idle(12);
        rd(2'd0, 32'h001, "t2_rd_dir");
        rd(2'd1, 32'd5, "t2_rd_duty");
        rd(2'd2, (32'(2) << 18) | (32'(5) << 12) | 32'h001, "t2_status");

        // 3: dir change at duty 5: ramp down, 1 detect + 8 dead + 1 write cycle, dir 3, ramp up
        for (int k = 4; k >= 0; k--) expect_wr(1'b1, 32'(k), (k == 4) ? 0 : 4, "t3_down");
        expect_wr(1'b0, 32'h003, 10, "t3_dir");
        for (int k = 1; k <= 5; k++) expect_wr(1'b1, 32'(k), (k == 1) ? 0 : 4, "t3_up");
        host_write(2'd0, 32'h003);
        wait_drain(120, "t3");
        rd(2'd2, (32'(2) << 18) | (32'(5) << 12) | 32'h003, "t3_status");

        // 4: dir reverts during deadtime: no dir write, back to TRACK, duty recovers
        for (int k = 4; k >= 0; k--) expect_wr(1'b1, 32'(k), (k == 4) ? 0 : 4, "t4_down");
        host_write(2'd0, 32'h007);
        wait_status(ST_MASK, 32'(4) << 18, 60, "t4_in_deadtime");
        for (int k = 1; k <= 5; k++) expect_wr(1'b1, 32'(k), (k == 1) ? 0 : 4, "t4_up");
        host_write(2'd0, 32'h003);
        wait_status(ST_MASK, 32'(2) << 18, 10, "t4_back_track");
        wait_drain(60, "t4");
        rd(2'd2, (32'(2) << 18) | (32'(5) << 12) | 32'h003, "t4_status");

        // 5: host silence trips watchdog: ramp to 0, dir 0; ctrl bit0 clears the flag
        for (int k = 4; k >= 0; k--) expect_wr(1'b1, 32'(k), (k == 4) ? 0 : 4, "t5_down");
        expect_wr(1'b0, 32'h000, 10, "t5_dir");
        wait_drain(400, "t5");
        chk("t5_wdt_set", {31'b0, wdt_tripped}, 32'd1);
        rd(2'd0, 32'd0, "t5_tgt_dir");
        rd(2'd1, 32'd0, "t5_tgt_duty");
        host_write(2'd3, 32'd1);
        chk("t5_wdt_clr", {31'b0, wdt_tripped}, 32'd0);

        // 6: reset during RAMP_DOWN at duty 3 aborts and replays INIT
        expect_wr(1'b0, 32'h001, 0, "t6_dir");
        for (int k = 1; k <= 3; k++) expect_wr(1'b1, 32'(k), (k == 1) ? 0 : 4, "t6_up");
        host_write(2'd0, 32'h001);
        host_write(2'd1, 32'd3);
        wait_status(DUTY_MASK, 32'(3) << 12, 80, "t6_duty3");
        host_write(2'd0, 32'h002);
        wait_status(ST_MASK | DUTY_MASK, (32'(3) << 18) | (32'(3) << 12), 10, "t6_rampdown");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_out_write", {31'b0, out_write}, 32'd0);
        chk("t6_rst_out_addr", {31'b0, out_addr}, 32'd0);
        chk("t6_rst_out_data", out_writedata, 32'd0);
        chk("t6_rst_status", readdata, 32'd0);
        expect_wr(1'b1, 32'd0, 0, "t6_init1");
        expect_wr(1'b0, 32'd0, 1, "t6_init2");
        reset = 1'b0;
        wait_drain(10, "t6");
        idle(12);
        rd(2'd2, 32'(2) << 18, "t6_status");
        chk("final_pending", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
